// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial comparator controller.
//   state_e       : FSM state encodings (IDLE, SCAN, DONE)
//   DEFAULT_WIDTH : default operand width used by serial_compare_ctrl
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_cmp_pkg

// File: rtl/comparator_1bit.sv
// Single-bit magnitude comparator cell.
//   a_i, b_i : input bits
//   gt_o     : a_i > b_i
//   lt_o     : a_i < b_i
//   eq_o     : a_i == b_i
module comparator_1bit (
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic lt_o,
  output logic eq_o
);

  assign gt_o = a_i & ~b_i;
  assign lt_o = ~a_i & b_i;
  assign eq_o = ~(a_i ^ b_i);

endmodule : comparator_1bit

// File: rtl/serial_compare_ctrl.sv
// Serial unsigned magnitude comparator. On an accepted start the operands
// are captured and examined one bit per cycle, MSB first, through a single
// 1-bit comparator cell. The scan stops at the first differing bit, or after
// the LSB when all bits match, and reports a one-hot result with a one-cycle
// done pulse.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request a comparison (accepted only when idle)
//   abort   : cancel a scan in progress (no done, results stay 0)
//   a, b    : operands, sampled when start is accepted
//   busy    : high while scanning or reporting
//   done    : one-cycle pulse, results valid
//   a_gt_b  : A > B (unsigned)
//   a_lt_b  : A < B (unsigned)
//   a_eq_b  : A == B
module serial_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               gt_q;
  logic               lt_q;
  logic               eq_q;

  logic               cmp_gt;
  logic               cmp_lt;
  logic               cmp_eq;

  comparator_1bit u_cmp (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .gt_o (cmp_gt),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // start wins over abort here; abort only matters while scanning
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= IDX_W'(WIDTH - 1);
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          // abort pre-empts the compare; results were cleared at accept
          if (abort) begin
            state_q <= IDLE;
          end else if (!cmp_eq) begin
            gt_q    <= cmp_gt;
            lt_q    <= cmp_lt;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Moore decode from state; results come straight from their registers
  assign busy   = (state_q == SCAN) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule : serial_compare_ctrl

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl (WIDTH=8): directed vector
// table, hand-written abort/reset/hold sequences, and random back-to-back
// compares against an unsigned reference.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         a_gt_b;
  logic         a_lt_b;
  logic         a_eq_b;

  int n_checks  = 0;
  int n_pass    = 0;
  int done_cnt  = 0;
  int exp_dones = 0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gt;
    logic         lt;
    logic         eq;
    int           k;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input bit ok, input string nm, input string got, input string want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, got, want);
  endtask

  function automatic string res_s();
    return $sformatf("busy=%b done=%b gt/lt/eq=%b%b%b", busy, done, a_gt_b, a_lt_b, a_eq_b);
  endfunction

  // Entered and left at a falling edge with the DUT idle.
  // ab_mode: 0 none, 1 abort raised together with start, 2 abort held during DONE.
  task automatic run_cmp(input logic [W-1:0] ua, input logic [W-1:0] ub,
                         input logic eg, input logic el, input logic ee,
                         input int ek, input string nm, input int ab_mode);
    int n;
    bit busy_ok;
    a = ua; b = ub; start = 1'b1; abort = (ab_mode == 1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk(busy && !done && !a_gt_b && !a_lt_b && !a_eq_b, {nm, " accept"},
        res_s(), "busy=1 done=0 gt/lt/eq=000");
    n = 0; busy_ok = 1'b1;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    chk(done && n == ek && busy_ok, {nm, " latency"},
        $sformatf("done=%b after %0d cycles busy_ok=%b", done, n, busy_ok),
        $sformatf("done=1 after %0d cycles busy_ok=1", ek));
    chk({a_gt_b, a_lt_b, a_eq_b} == {eg, el, ee}, {nm, " result"},
        $sformatf("%b%b%b", a_gt_b, a_lt_b, a_eq_b), $sformatf("%b%b%b", eg, el, ee));
    exp_dones++;
    if (ab_mode == 2) abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(!done && !busy && {a_gt_b, a_lt_b, a_eq_b} == {eg, el, ee}, {nm, " after"},
        res_s(), $sformatf("busy=0 done=0 gt/lt/eq=%b%b%b", eg, el, ee));
  endtask

  initial begin
    bit ok;
    logic [W-1:0] ra, rb;
    int rk;

    vecs[0] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 8};
    vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8};
    vecs[3] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8};
    vecs[4] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[6] = '{8'h40, 8'h20, 1'b1, 1'b0, 1'b0, 2};
    vecs[7] = '{8'h0F, 8'h1F, 1'b0, 1'b1, 1'b0, 4};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8};
    vecs[9] = '{8'h33, 8'h31, 1'b1, 1'b0, 1'b0, 7};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk(!busy && !done && !a_gt_b && !a_lt_b && !a_eq_b, "reset", res_s(), "all 0");
    rst_n = 1'b1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 10; i++)
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].lt, vecs[i].eq, vecs[i].k,
              $sformatf("vec%0d", i), 0);

    // results hold through idle cycles; next accept clears them
    run_cmp(8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8, "hold_setup", 2);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (busy || done || !a_lt_b || a_gt_b || a_eq_b) ok = 1'b0;
      @(negedge clk);
    end
    chk(ok, "hold 5 idle", res_s(), "lt held, idle");
    run_cmp(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1, "after_hold", 0);

    // start and abort together in IDLE: start wins
    run_cmp(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 7, "start_abort", 1);

    // abort at 3rd SCAN cycle, start re-pulsed mid-scan
    a = 8'h00; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(!busy && !done && !a_gt_b && !a_lt_b && !a_eq_b, "abort idle", res_s(), "all 0");
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy || a_gt_b || a_lt_b || a_eq_b) ok = 1'b0;
    end
    chk(ok, "abort no done", res_s(), "stays idle, no done");

    // asynchronous reset mid-SCAN
    a = 8'h00; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk(busy, "pre-reset busy", $sformatf("busy=%b", busy), "busy=1");
    #2 rst_n = 1'b0;
    #1;
    chk(!busy && !done && !a_gt_b && !a_lt_b && !a_eq_b, "async reset", res_s(), "all 0");
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(!busy && !done, "post-reset idle", res_s(), "busy=0 done=0");
    run_cmp(8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8, "post_reset", 0);

    // random back-to-back compares
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      rk = 0;
      for (int j = W - 1; j >= 0; j--) begin
        rk++;
        if (ra[j] != rb[j]) break;
      end
      run_cmp(ra, rb, ra > rb, ra < rb, ra == rb, rk, $sformatf("rnd%0d", i), 0);
    end

    @(negedge clk);
    chk(done_cnt == exp_dones, "done count",
        $sformatf("%0d", done_cnt), $sformatf("%0d", exp_dones));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_compare_ctrl
